// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the single-port DMEM.
// Every DMEM control/data output comes straight from a flop, so the write enable never glitches.
module dmem_arbiter #(
  parameter int DEPTH_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_done,
  output logic        p1_done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic        oor_q, oor_d;
  logic        last_q, last_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_data_in_q, mem_data_in_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_read_q, mem_read_d;
  logic        p0_done_q, p0_done_d;
  logic        p1_done_q, p1_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        sel_we;
  logic        sel_oor;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  // A tie goes to the port that was not served last; a lone requester always wins.
  always_comb begin
    p0_gnt    = (state_q != ACCESS) && p0_req && (!p1_req || last_q);
    p1_gnt    = (state_q != ACCESS) && p1_req && (!p0_req || !last_q);
    accept    = p0_gnt || p1_gnt;
    sel_we    = p1_gnt ? p1_we    : p0_we;
    sel_addr  = p1_gnt ? p1_addr  : p0_addr;
    sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
    sel_oor   = (sel_addr >> DEPTH_BITS) != 32'd0;
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    we_d          = we_q;
    oor_d         = oor_q;
    last_d        = last_q;
    mem_address_d = 32'd0;
    mem_data_in_d = 32'd0;
    mem_write_d   = 1'b0;
    mem_read_d    = 1'b0;
    p0_done_d     = 1'b0;
    p1_done_d     = 1'b0;
    rdata_d       = rdata_q;
    err_d         = err_q;
    case (state_q)
      ACCESS: begin
        rdata_d   = (we_q || oor_q) ? 32'd0 : mem_data_out;
        err_d     = oor_q;
        p0_done_d = !owner_q;
        p1_done_d = owner_q;
        state_d   = DONE;
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          owner_d       = p1_gnt;
          last_d        = p1_gnt;
          we_d          = sel_we;
          oor_d         = sel_oor;
          mem_address_d = sel_addr;
          mem_data_in_d = sel_wdata;
          mem_write_d   = sel_we && !sel_oor;
          mem_read_d    = !sel_we && !sel_oor;
          state_d       = ACCESS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      we_q          <= 1'b0;
      oor_q         <= 1'b0;
      last_q        <= 1'b1;
      mem_address_q <= 32'd0;
      mem_data_in_q <= 32'd0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      p0_done_q     <= 1'b0;
      p1_done_q     <= 1'b0;
      rdata_q       <= 32'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      oor_q         <= oor_d;
      last_q        <= last_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_write_q   <= mem_write_d;
      mem_read_q    <= mem_read_d;
      p0_done_q     <= p0_done_d;
      p1_done_q     <= p1_done_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
    end
  end

  assign p0_done     = p0_done_q;
  assign p1_done     = p1_done_q;
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_write   = mem_write_q;
  assign mem_read    = mem_read_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a per-cycle vector table plus a reset-during-access sequence,
// with a small behavioural DMEM attached to the mem_* port.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_done, p1_done, err, mem_write, mem_read;
  logic [31:0] rdata, mem_address, mem_data_in, mem_data_out;

  logic [31:0] dmem [256];
  int          errors;
  int          checks;

  typedef struct packed {
    logic        r0;
    logic        w0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        r1;
    logic        w1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic        g0;
    logic        g1;
    logic        dn0;
    logic        dn1;
    logic        mrd;
    logic        mwr;
    logic [31:0] maddr;
    logic [31:0] mdin;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t vecs [25];

  dmem_arbiter #(.DEPTH_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
    .rdata(rdata), .err(err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write(mem_write), .mem_read(mem_read), .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DMEM model: combinational read, write on the rising edge while mem_write is high.
  assign mem_data_out = dmem[mem_address[7:0]];
  always @(posedge clk) begin
    if (mem_write) dmem[mem_address[7:0]] <= mem_data_in;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    p0_req = v.r0; p0_we = v.w0; p0_addr = v.a0; p0_wdata = v.d0;
    p1_req = v.r1; p1_we = v.w1; p1_addr = v.a1; p1_wdata = v.d1;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " p0_gnt"}, {31'd0, p0_gnt}, 32'd0);
    check_output({tag, " p1_gnt"}, {31'd0, p1_gnt}, 32'd0);
    check_output({tag, " p0_done"}, {31'd0, p0_done}, 32'd0);
    check_output({tag, " p1_done"}, {31'd0, p1_done}, 32'd0);
    check_output({tag, " mem_read"}, {31'd0, mem_read}, 32'd0);
    check_output({tag, " mem_write"}, {31'd0, mem_write}, 32'd0);
    check_output({tag, " mem_address"}, mem_address, 32'd0);
    check_output({tag, " mem_data_in"}, mem_data_in, 32'd0);
    check_output({tag, " rdata"}, rdata, 32'd0);
    check_output({tag, " err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    dmem[0] = 32'hA5A5A5A5;
    dmem[5] = 32'hDEADBEEF;

    //          r0 w0 a0      d0            r1 w1 a1     d1            g0 g1 dn0 dn1 mrd mwr maddr   mdin          rdata         err
    vecs[0]  = '{1, 0, 32'h5,  32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,        0};
    vecs[1]  = '{0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 1, 0, 32'h5,   32'h0,        32'h0,        0};
    vecs[2]  = '{0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 1, 0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 0};
    vecs[3]  = '{0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 0};
    vecs[4]  = '{0, 0, 32'h0,  32'h0,        1, 1, 32'h20, 32'h12345678, 0, 1, 0, 0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 0};
    vecs[5]  = '{0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 1, 32'h20,  32'h12345678, 32'hDEADBEEF, 0};
    vecs[6]  = '{0, 0, 32'h0,  32'h0,        1, 0, 32'h20, 32'h0,        0, 1, 0, 1, 0, 0, 32'h0,   32'h0,        32'h0,        0};
    vecs[7]  = '{0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 1, 0, 32'h20,  32'h0,        32'h0,        0};
    vecs[8]  = '{0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 0, 32'h0,   32'h0,        32'h12345678, 0};
    vecs[9]  = '{1, 0, 32'h5,  32'h0,        1, 0, 32'h20, 32'h0,        1, 0, 0, 0, 0, 0, 32'h0,   32'h0,        32'h12345678, 0};
    vecs[10] = '{1, 0, 32'h5,  32'h0,        1, 0, 32'h20, 32'h0,        0, 0, 0, 0, 1, 0, 32'h5,   32'h0,        32'h12345678, 0};
    vecs[11] = '{1, 0, 32'h5,  32'h0,        1, 0, 32'h20, 32'h0,        0, 1, 1, 0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 0};
    vecs[12] = '{1, 0, 32'h5,  32'h0,        1, 0, 32'h20, 32'h0,        0, 0, 0, 0, 1, 0, 32'h20,  32'h0,        32'hDEADBEEF, 0};
    vecs[13] = '{1, 0, 32'h5,  32'h0,        1, 0, 32'h20, 32'h0,        1, 0, 0, 1, 0, 0, 32'h0,   32'h0,        32'h12345678, 0};
    vecs[14] = '{1, 0, 32'h5,  32'h0,        1, 0, 32'h20, 32'h0,        0, 0, 0, 0, 1, 0, 32'h5,   32'h0,        32'h12345678, 0};
    vecs[15] = '{0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 1, 0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 0};
    vecs[16] = '{0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 0};
    vecs[17] = '{1, 1, 32'h100, 32'hFFFFFFFF, 0, 0, 32'h0, 32'h0,        1, 0, 0, 0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 0};
    vecs[18] = '{0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 0, 32'h100, 32'hFFFFFFFF, 32'hDEADBEEF, 0};
    vecs[19] = '{0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 1, 0, 0, 0, 32'h0,   32'h0,        32'h0,        1};
    vecs[20] = '{0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,        1};
    vecs[21] = '{1, 0, 32'h5,  32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,        1};
    vecs[22] = '{0, 0, 32'h0,  32'h0,        1, 0, 32'h20, 32'h0,        0, 0, 0, 0, 1, 0, 32'h5,   32'h0,        32'h0,        1};
    vecs[23] = '{0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 1, 0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 0};
    vecs[24] = '{0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 0};

    rst_n = 1'b0;
    apply_stimulus('0);
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("v%0d p0_gnt", i), {31'd0, p0_gnt}, {31'd0, vecs[i].g0});
      check_output($sformatf("v%0d p1_gnt", i), {31'd0, p1_gnt}, {31'd0, vecs[i].g1});
      check_output($sformatf("v%0d p0_done", i), {31'd0, p0_done}, {31'd0, vecs[i].dn0});
      check_output($sformatf("v%0d p1_done", i), {31'd0, p1_done}, {31'd0, vecs[i].dn1});
      check_output($sformatf("v%0d mem_read", i), {31'd0, mem_read}, {31'd0, vecs[i].mrd});
      check_output($sformatf("v%0d mem_write", i), {31'd0, mem_write}, {31'd0, vecs[i].mwr});
      check_output($sformatf("v%0d mem_address", i), mem_address, vecs[i].maddr);
      check_output($sformatf("v%0d mem_data_in", i), mem_data_in, vecs[i].mdin);
      check_output($sformatf("v%0d rdata", i), rdata, vecs[i].rd);
      check_output($sformatf("v%0d err", i), {31'd0, err}, {31'd0, vecs[i].er});
    end

    check_output("dmem[0] untouched by out-of-range write", dmem[0], 32'hA5A5A5A5);
    check_output("dmem[0x20] written", dmem[32'h20], 32'h12345678);

    // Reset lands while a p1 read is in ACCESS: everything clears, no done follows.
    @(negedge clk);
    apply_stimulus('0);
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h20;
    #1;
    check_output("rst seq p1_gnt", {31'd0, p1_gnt}, 32'd1);
    @(negedge clk);
    apply_stimulus('0);
    #1;
    check_output("rst seq mem_read in access", {31'd0, mem_read}, 32'd1);
    check_output("rst seq mem_address in access", mem_address, 32'h20);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid-access reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_output($sformatf("post-reset p1_done c%0d", i), {31'd0, p1_done}, 32'd0);
      check_output($sformatf("post-reset mem_read c%0d", i), {31'd0, mem_read}, 32'd0);
    end
    @(negedge clk);
    p0_req = 1'b1; p0_addr = 32'h5;
    p1_req = 1'b1; p1_addr = 32'h20;
    #1;
    check_output("post-reset tie p0_gnt", {31'd0, p0_gnt}, 32'd1);
    check_output("post-reset tie p1_gnt", {31'd0, p1_gnt}, 32'd0);
    @(negedge clk);
    apply_stimulus('0);
    @(negedge clk);
    #1;
    check_output("post-reset p0 read done", {31'd0, p0_done}, 32'd1);
    check_output("post-reset p0 read rdata", rdata, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
